unit_arbiter: RTL and testbench
===============================

UNIT_ARBITER -- requirements
Module: unit_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the compute unit (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, width of the operand sent to the unit.
REQ-003 Parameter DOUT_WIDTH, default 16, width of the result returned by the unit.
REQ-004 Parameter TIMEOUT, default 255, maximum WAIT cycles before an error response (1..65535).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 nrst  input  1  reset; synchronous, active-low.
REQ-007 req  input  NREQ  per-requester level request; held until that requester's resp_valid bit.
REQ-008 req_data  input  NREQ*DATA_WIDTH  operands, packed; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 gnt  output  NREQ  one-hot grant; zero when no transaction is active.
REQ-010 resp_valid  output  NREQ  one-hot, single-cycle response strobe.
REQ-011 resp_data  output  DOUT_WIDTH  result for the strobed requester.
REQ-012 resp_err  output  1  qualifies resp_valid; 1 means timeout.
REQ-013 unit_start  output  1  single-cycle launch pulse to the shared unit.
REQ-014 unit_din  output  DATA_WIDTH  operand to the unit; valid while unit_start=1.
REQ-015 unit_done  input  1  unit completion pulse.
REQ-016 unit_dout  input  DOUT_WIDTH  unit result; valid while unit_done=1.
REQ-017 busy  output  1  1 in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP. Exactly one transaction is in flight at a time.
REQ-019 IDLE with req!=0:
- select the first set bit searching upward from pointer ptr, wrapping modulo NREQ;
- register its index and req_data slice;
- next state ISSUE.
REQ-020 IDLE with req==0: remain in IDLE; gnt=0.
REQ-021 ISSUE (one cycle): gnt[idx]=1, unit_start=1, unit_din=captured operand; next state WAIT.
REQ-022 WAIT: gnt[idx] held; 16-bit wait counter cleared on entry and incremented every WAIT cycle.
REQ-023 WAIT exit on unit_done=1: capture unit_dout, clear the error flag, next state RESP.
REQ-024 WAIT exit on timeout (counter reaches TIMEOUT with unit_done=0): capture result 0, set the error flag, next state RESP.
REQ-025 unit_done and timeout in the same cycle: unit_done wins and resp_err=0.
REQ-026 RESP (one cycle):
- resp_valid[idx]=1, resp_err=error flag, gnt[idx] still 1;
- ptr <= (idx+1) mod NREQ;
- next state IDLE.
REQ-027 resp_data is registered and holds its last value until the next RESP.
REQ-028 Latency: req seen in IDLE at cycle t gives unit_start at t+1. unit_done at cycle w (in WAIT) gives resp_valid at w+1. Back-to-back grants are separated by exactly one IDLE cycle.
REQ-029 unit_done outside WAIT is ignored and does not alter state or outputs.
REQ-030 Deassertion of the granted requester's req mid-transaction does not abort; its response is still issued.
REQ-031 req_data changes after capture do not affect unit_din.
REQ-032 Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0 with no requester skipped.

Reset
REQ-033 While nrst=0 at a rising edge, the block SHALL take these values:
- state=IDLE, ptr=0, wait counter=0, error flag=0;
- gnt=0, resp_valid=0, resp_data=0, resp_err=0;
- unit_start=0, unit_din=0, busy=0.
REQ-034 Reset asserted mid-transaction abandons it: no resp_valid is issued, and a later unit_done is ignored per REQ-029.

Verification
REQ-035 NREQ=4, req=4'b0100, data2=8'h5A, unit_done 3 cycles after unit_start with dout=16'h1234 -> one unit_start with din=8'h5A, then resp_valid=4'b0100, resp_data=16'h1234, resp_err=0.
REQ-036 req=4'b1111 held, unit answers with 2-cycle latency -> grant order 0,1,2,3,0, each requester receives exactly one resp_valid per rotation.
REQ-037 TIMEOUT=4, unit never answers -> resp_valid after 4 WAIT cycles, resp_err=1, resp_data=0, then the FSM returns to IDLE.
REQ-038 TIMEOUT=4, unit_done on the 4th WAIT cycle -> resp_err=0 and resp_data=unit_dout.
REQ-039 nrst=0 for one cycle during WAIT, then a stray unit_done -> all outputs at reset values, no resp_valid, busy=0.
REQ-040 ptr=3, req=4'b1001 -> grant 3, then grant 0 (wrap-around), while req_data3 changing after ISSUE leaves unit_din unchanged.

Source files
------------

// File: rtl/unit_arbiter.sv
// Purpose : round-robin arbiter that time-shares one compute unit among NREQ requesters.
// Latency : req seen in IDLE -> unit_start next cycle; unit_done -> resp_valid next cycle; one IDLE cycle between grants.
// Backpressure : one transaction in flight; requesters hold req until their resp_valid strobe, and a silent unit is cut off by TIMEOUT.
//
// Ports:
//   clk, nrst              clock and synchronous active-low reset
//   req, req_data          per-requester level request and packed operands (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   gnt                    one-hot grant for the transaction in flight, zero when idle
//   resp_valid/_data/_err  one-cycle response strobe, registered result, timeout flag
//   unit_start, unit_din   launch pulse and captured operand to the shared unit
//   unit_done, unit_dout   completion pulse and result from the shared unit
//   busy                   high whenever the FSM is not in IDLE

module unit_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DOUT_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            resp_valid,
    output logic [DOUT_WIDTH-1:0]      resp_data,
    output logic                       resp_err,
    output logic                       unit_start,
    output logic [DATA_WIDTH-1:0]      unit_din,
    input  logic                       unit_done,
    input  logic [DOUT_WIDTH-1:0]      unit_dout,
    output logic                       busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           pick_idx;
    logic                    pick_vld;
    logic [DATA_WIDTH-1:0]   op_q;
    logic [15:0]             wait_cnt;
    logic                    err_q;
    logic [DOUT_WIDTH-1:0]   resp_data_q;
    logic                    timeout_hit;
    logic [DATA_WIDTH-1:0]   req_op [NREQ];

    // Unpack the operand bus once so the capture mux indexes a plain array.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_op[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first set request at or above ptr, wrapping modulo NREQ.
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        jj       = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IW'(j);
            if (!pick_vld && req[jj]) begin
                pick_vld = 1'b1;
                pick_idx = jj;
            end
        end
    end

    // The counter holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle is the one where it reads TIMEOUT-1.
    assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs. Every output is decoded from registered state,
    // so nothing on the request or unit side reaches an output combinationally.
    always_comb begin
        state_nxt  = state;
        gnt        = '0;
        resp_valid = '0;
        resp_err   = 1'b0;
        unit_start = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (pick_vld) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gnt[idx]   = 1'b1;
                unit_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                gnt[idx] = 1'b1;
                if (unit_done || timeout_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                gnt[idx]        = 1'b1;
                resp_valid[idx] = 1'b1;
                resp_err        = err_q;
                state_nxt       = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transaction datapath: captured index/operand, wait counter, result.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ptr         <= '0;
            idx         <= '0;
            op_q        <= '0;
            wait_cnt    <= '0;
            err_q       <= 1'b0;
            resp_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        idx  <= pick_idx;
                        op_q <= req_op[pick_idx];
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // A completion in the timeout cycle is still a good result.
                    if (unit_done) begin
                        resp_data_q <= unit_dout;
                        err_q       <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data_q <= '0;
                        err_q       <= 1'b1;
                    end
                end
                S_RESP: begin
                    ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign unit_din  = op_q;
    assign resp_data = resp_data_q;

`ifndef SYNTHESIS
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!nrst) $onehot0(gnt));
    a_resp_in_gnt : assert property (@(posedge clk) disable iff (!nrst)
                                     (resp_valid != '0) |-> (resp_valid == gnt));
`endif

endmodule

// File: tb/tb_unit_arbiter.sv
module tb_unit_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        unit_start;
    logic [7:0]  unit_din;
    logic        unit_done;
    logic [15:0] unit_dout;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    int   rv_cnt [4];
    logic cnt_en = 1'b0;

    unit_arbiter #(
        .NREQ      (4),
        .DATA_WIDTH(8),
        .DOUT_WIDTH(16),
        .TIMEOUT   (4)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .unit_start(unit_start),
        .unit_din  (unit_din),
        .unit_done (unit_done),
        .unit_dout (unit_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (cnt_en) begin
            for (int k = 0; k < 4; k++) begin
                if (resp_valid[k]) begin
                    rv_cnt[k] = rv_cnt[k] + 1;
                end
            end
        end
    end

    typedef struct {
        logic        nrst;
        logic [3:0]  req;
        logic [31:0] data;
        logic        done;
        logic [15:0] dout;
        logic [3:0]  gnt;
        logic [3:0]  rv;
        logic [15:0] rd;
        logic        err;
        logic        start;
        logic        chk_din;
        logic [7:0]  din;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic n, input logic [3:0] r, input logic [31:0] d,
                         input logic dn, input logic [15:0] dout);
        nrst      = n;
        req       = r;
        req_data  = d;
        unit_done = dn;
        unit_dout = dout;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " gnt"},   32'(gnt), 32'h0);
        chk({tag, " rv"},    32'(resp_valid), 32'h0);
        chk({tag, " start"}, 32'(unit_start), 32'h0);
        chk({tag, " busy"},  32'(busy), 32'h0);
    endtask

    initial begin
        logic [3:0] oh;
        int         id;

        // nrst req data done dout | gnt rv rd err start chk_din din busy
        vecs.push_back('{1'b1, 4'b0000, 32'h00000000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 4'b0100, 32'h005A0000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 4'b0100, 32'h00FF0000, 1'b0, 16'h0000, 4'b0100, 4'b0000, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1});
        vecs.push_back('{1'b1, 4'b0100, 32'h00FF0000, 1'b0, 16'h0000, 4'b0100, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 4'b0100, 32'h00FF0000, 1'b0, 16'h0000, 4'b0100, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 4'b0100, 32'h00FF0000, 1'b1, 16'h1234, 4'b0100, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 4'b0000, 32'h00000000, 1'b0, 16'h0000, 4'b0100, 4'b0100, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
        // stray unit_done while idle must be ignored
        vecs.push_back('{1'b1, 4'b0000, 32'h00000000, 1'b1, 16'hBEEF, 4'b0000, 4'b0000, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 4'b0000, 32'h00000000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        // ptr is now 3: requesters 3 and 0 compete, 3 first, then wrap to 0
        vecs.push_back('{1'b1, 4'b1001, 32'hC3000011, 1'b0, 16'h0000, 4'b0000, 4'b0000, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 4'b1001, 32'h77000011, 1'b0, 16'h0000, 4'b1000, 4'b0000, 16'h1234, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1});
        vecs.push_back('{1'b1, 4'b1001, 32'h77000011, 1'b1, 16'h0C3C, 4'b1000, 4'b0000, 16'h1234, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1});
        vecs.push_back('{1'b1, 4'b0001, 32'h77000011, 1'b0, 16'h0000, 4'b1000, 4'b1000, 16'h0C3C, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1});
        vecs.push_back('{1'b1, 4'b0001, 32'h00000011, 1'b0, 16'h0000, 4'b0000, 4'b0000, 16'h0C3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 4'b0001, 32'h00000011, 1'b0, 16'h0000, 4'b0001, 4'b0000, 16'h0C3C, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1});
        vecs.push_back('{1'b1, 4'b0001, 32'h00000011, 1'b1, 16'h0011, 4'b0001, 4'b0000, 16'h0C3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 4'b0000, 32'h00000000, 1'b0, 16'h0000, 4'b0001, 4'b0001, 16'h0011, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 4'b0000, 32'h00000000, 1'b0, 16'h0000, 4'b0000, 4'b0000, 16'h0011, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});

        for (int k = 0; k < 4; k++) begin
            rv_cnt[k] = 0;
        end

        drive(1'b0, 4'b0000, 32'h0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);

        // Table: inputs are applied and outputs checked at each falling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].nrst, vecs[i].req, vecs[i].data, vecs[i].done, vecs[i].dout);
            chk($sformatf("v%0d gnt", i),   32'(gnt),        32'(vecs[i].gnt));
            chk($sformatf("v%0d rv", i),    32'(resp_valid), 32'(vecs[i].rv));
            chk($sformatf("v%0d rdata", i), 32'(resp_data),  32'(vecs[i].rd));
            chk($sformatf("v%0d rerr", i),  32'(resp_err),   32'(vecs[i].err));
            chk($sformatf("v%0d start", i), 32'(unit_start), 32'(vecs[i].start));
            chk($sformatf("v%0d busy", i),  32'(busy),       32'(vecs[i].busy));
            if (vecs[i].chk_din) begin
                chk($sformatf("v%0d din", i), 32'(unit_din), 32'(vecs[i].din));
            end
        end

        // Reset pulse during WAIT abandons the transaction; a later done is ignored.
        @(negedge clk);
        drive(1'b1, 4'b0010, 32'h00002200, 1'b0, 16'h0);
        chk_idle("rst idle");
        @(negedge clk);
        chk("rst issue gnt", 32'(gnt), 32'h2);
        chk("rst issue din", 32'(unit_din), 32'h22);
        @(negedge clk);
        chk("rst wait busy", 32'(busy), 32'h1);
        drive(1'b0, 4'b0010, 32'h00002200, 1'b0, 16'h0);
        @(negedge clk);
        drive(1'b1, 4'b0000, 32'h0, 1'b1, 16'hDEAD);
        chk_idle("rst after");
        chk("rst after rdata", 32'(resp_data), 32'h0);
        chk("rst after rerr",  32'(resp_err), 32'h0);
        chk("rst after din",   32'(unit_din), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 4'b0000, 32'h0, 1'b0, 16'h0);
            chk_idle($sformatf("rst stray%0d", c));
            chk($sformatf("rst stray%0d rdata", c), 32'(resp_data), 32'h0);
        end

        // All four requesting, unit answers two cycles after start: 0,1,2,3,0.
        cnt_en = 1'b1;
        for (int g = 0; g < 5; g++) begin
            id = g % 4;
            oh = 4'b0001 << id;
            @(negedge clk);
            drive(1'b1, 4'b1111, 32'h33323130, 1'b0, 16'h0);
            chk_idle($sformatf("rr%0d idle", g));
            @(negedge clk);
            chk($sformatf("rr%0d gnt", g),   32'(gnt), 32'(oh));
            chk($sformatf("rr%0d start", g), 32'(unit_start), 32'h1);
            chk($sformatf("rr%0d din", g),   32'(unit_din), 32'h30 + 32'(id));
            @(negedge clk);
            chk($sformatf("rr%0d w1 rv", g), 32'(resp_valid), 32'h0);
            @(negedge clk);
            drive(1'b1, 4'b1111, 32'h33323130, 1'b1, 16'hA000 + 16'(id));
            chk($sformatf("rr%0d w2 rv", g), 32'(resp_valid), 32'h0);
            @(negedge clk);
            drive(1'b1, 4'b1111, 32'h33323130, 1'b0, 16'h0);
            chk($sformatf("rr%0d rv", g),    32'(resp_valid), 32'(oh));
            chk($sformatf("rr%0d rdata", g), 32'(resp_data), 32'hA000 + 32'(id));
            chk($sformatf("rr%0d rerr", g),  32'(resp_err), 32'h0);
        end
        @(negedge clk);
        drive(1'b1, 4'b0000, 32'h0, 1'b0, 16'h0);
        chk_idle("rr end");
        cnt_en = 1'b0;
        chk("rr count0", 32'(rv_cnt[0]), 32'd2);
        chk("rr count1", 32'(rv_cnt[1]), 32'd1);
        chk("rr count2", 32'(rv_cnt[2]), 32'd1);
        chk("rr count3", 32'(rv_cnt[3]), 32'd1);

        // Unit never answers: error response after exactly four WAIT cycles.
        @(negedge clk);
        drive(1'b1, 4'b0010, 32'h00004400, 1'b0, 16'h0);
        chk_idle("to idle");
        @(negedge clk);
        chk("to issue gnt", 32'(gnt), 32'h2);
        chk("to issue din", 32'(unit_din), 32'h44);
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            chk($sformatf("to w%0d rv", w),   32'(resp_valid), 32'h0);
            chk($sformatf("to w%0d gnt", w),  32'(gnt), 32'h2);
            chk($sformatf("to w%0d busy", w), 32'(busy), 32'h1);
        end
        @(negedge clk);
        drive(1'b1, 4'b0000, 32'h0, 1'b0, 16'h0);
        chk("to rv",    32'(resp_valid), 32'h2);
        chk("to rerr",  32'(resp_err), 32'h1);
        chk("to rdata", 32'(resp_data), 32'h0);
        @(negedge clk);
        chk_idle("to back idle");
        chk("to back rerr", 32'(resp_err), 32'h0);

        // Completion on the fourth WAIT cycle beats the timeout.
        @(negedge clk);
        drive(1'b1, 4'b0100, 32'h00550000, 1'b0, 16'h0);
        chk_idle("tie idle");
        @(negedge clk);
        chk("tie issue gnt", 32'(gnt), 32'h4);
        chk("tie issue din", 32'(unit_din), 32'h55);
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            if (w == 4) begin
                drive(1'b1, 4'b0100, 32'h00550000, 1'b1, 16'hBEEF);
            end
            chk($sformatf("tie w%0d rv", w), 32'(resp_valid), 32'h0);
        end
        @(negedge clk);
        drive(1'b1, 4'b0000, 32'h0, 1'b0, 16'h0);
        chk("tie rv",    32'(resp_valid), 32'h4);
        chk("tie rerr",  32'(resp_err), 32'h0);
        chk("tie rdata", 32'(resp_data), 32'hBEEF);
        @(negedge clk);
        chk_idle("tie back idle");
        chk("tie hold rdata", 32'(resp_data), 32'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
